// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves a sprite around the visible screen once per frame and bounces it
//   off the walls. A frame-refresh pulse starts a four-state update: the
//   X axis is stepped, then the Y axis, then both are committed together.
//   Position and direction outputs therefore change on a single edge.
//
//   Build option: define SPRITE_MOTION_BOUNCE_CNT_EN to build the saturating
//   wall-hit counter. Without it, BOUNCE_COUNT is tied to zero.
//
//   Ports
//     CLK          system clock, rising edge
//     RESET        synchronous active-high reset
//     REFRESH      one-cycle frame pulse from the VGA interface
//     ENABLE       motion enable; sampled together with REFRESH
//     SPEED[3:0]   pixels per frame, latched when an update starts
//     X[9:0]       sprite top-left horizontal position
//     Y[8:0]       sprite top-left vertical position
//     DIR_X        1 = right, 0 = left
//     DIR_Y        1 = down,  0 = up
//     BUSY         update in progress
//     BOUNCE       one-cycle strobe after a commit that hit any wall
//     BOUNCE_COUNT saturating wall-hit count
//
//   state  | meaning
//   IDLE   | waiting for REFRESH & ENABLE
//   STEP_X | compute next X / DIR_X into staging registers
//   STEP_Y | compute next Y / DIR_Y into staging registers
//   COMMIT | copy staging to outputs, raise BOUNCE on any hit

module sprite_motion_ctrl #(
    parameter int SPRITE_W = 80,
    parameter int SPRITE_H = 80,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int MARGIN   = 5,
    parameter int X_INIT   = 280,
    parameter int Y_INIT   = 200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REFRESH,
    input  logic       ENABLE,
    input  logic [3:0] SPEED,
    output logic [9:0] X,
    output logic [8:0] Y,
    output logic       DIR_X,
    output logic       DIR_Y,
    output logic       BUSY,
    output logic       BOUNCE,
    output logic [7:0] BOUNCE_COUNT
);

    localparam logic [10:0] XMIN = 11'(MARGIN);
    localparam logic [10:0] XMAX = 11'(SCREEN_W - SPRITE_W - MARGIN);
    localparam logic [10:0] YMIN = 11'(MARGIN);
    localparam logic [10:0] YMAX = 11'(SCREEN_H - SPRITE_H - MARGIN);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  spd;
    logic [10:0] x_stg;
    logic [10:0] y_stg;
    logic        dx_stg;
    logic        dy_stg;
    logic        hit_x;
    logic        hit_y;
    logic [12:0] x_res;
    logic [12:0] y_res;

    // Returns {hit, new_dir, new_pos}. A zero step never moves or flips,
    // even when the sprite already sits on a wall.
    function automatic logic [12:0] step_axis(
        input logic [10:0] pos,
        input logic        dir,
        input logic [3:0]  s,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] s_w;
        s_w = {7'd0, s};
        if (s == 4'd0)
            step_axis = {1'b0, dir, pos};
        else if (dir) begin
            if (pos + s_w >= hi)
                step_axis = {1'b1, 1'b0, hi};
            else
                step_axis = {1'b0, 1'b1, pos + s_w};
        end else begin
            if (pos <= lo + s_w)
                step_axis = {1'b1, 1'b1, lo};
            else
                step_axis = {1'b0, 1'b0, pos - s_w};
        end
    endfunction

    assign x_res = step_axis(x_stg, dx_stg, spd, XMIN, XMAX);
    assign y_res = step_axis(y_stg, dy_stg, spd, YMIN, YMAX);
    assign BUSY  = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REFRESH && ENABLE) state_nxt = STEP_X;
            STEP_X:  state_nxt = STEP_Y;
            STEP_Y:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            spd    <= 4'd0;
            x_stg  <= 11'(X_INIT);
            y_stg  <= 11'(Y_INIT);
            dx_stg <= 1'b0;
            dy_stg <= 1'b0;
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
            X      <= 10'(X_INIT);
            Y      <= 9'(Y_INIT);
            DIR_X  <= 1'b0;
            DIR_Y  <= 1'b0;
            BOUNCE <= 1'b0;
        end else begin
            BOUNCE <= 1'b0;
            case (state)
                IDLE: begin
                    if (REFRESH && ENABLE) begin
                        spd    <= SPEED;
                        x_stg  <= {1'b0, X};
                        y_stg  <= {2'b00, Y};
                        dx_stg <= DIR_X;
                        dy_stg <= DIR_Y;
                    end
                end
                STEP_X: {hit_x, dx_stg, x_stg} <= x_res;
                STEP_Y: {hit_y, dy_stg, y_stg} <= y_res;
                COMMIT: begin
                    // Staging is clamped to the bounds, so truncation is safe.
                    X      <= x_stg[9:0];
                    Y      <= y_stg[8:0];
                    DIR_X  <= dx_stg;
                    DIR_Y  <= dy_stg;
                    BOUNCE <= hit_x | hit_y;
                end
                default: ;
            endcase
        end
    end

`ifdef SPRITE_MOTION_BOUNCE_CNT_EN
    logic [7:0] bounce_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            bounce_cnt <= 8'd0;
        else if (state == COMMIT && (hit_x || hit_y) && bounce_cnt != 8'hFF)
            bounce_cnt <= bounce_cnt + 8'd1;
    end

    assign BOUNCE_COUNT = bounce_cnt;
`else
    assign BOUNCE_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

`ifdef SPRITE_MOTION_BOUNCE_CNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] speed = 4'd0;
    logic       refresh_a = 1'b0;
    logic       refresh_b = 1'b0;

    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic       dx_a, dx_b, dy_a, dy_b;
    logic       busy_a, busy_b, bounce_a, bounce_b;
    logic [7:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut_a (
        .CLK(clk), .RESET(rst), .REFRESH(refresh_a), .ENABLE(enable), .SPEED(speed),
        .X(x_a), .Y(y_a), .DIR_X(dx_a), .DIR_Y(dy_a),
        .BUSY(busy_a), .BOUNCE(bounce_a), .BOUNCE_COUNT(cnt_a)
    );

    // Second instance parked in the top-left corner for the corner and abort cases.
    sprite_motion_ctrl #(.X_INIT(5), .Y_INIT(5)) dut_b (
        .CLK(clk), .RESET(rst), .REFRESH(refresh_b), .ENABLE(enable), .SPEED(speed),
        .X(x_b), .Y(y_b), .DIR_X(dx_b), .DIR_Y(dy_b),
        .BUSY(busy_b), .BOUNCE(bounce_b), .BOUNCE_COUNT(cnt_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One refresh pulse on the chosen instance; SPEED is scrambled right after
    // the start edge. Counts BUSY and BOUNCE cycles over the following 5 cycles.
    task automatic run_frame(input bit sel, input logic [3:0] spd,
                             output int busy_cyc, output int hits);
        @(negedge clk);
        speed = spd;
        if (sel) refresh_b = 1'b1; else refresh_a = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
        refresh_b = 1'b0;
        speed = ~spd;
        busy_cyc = 0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            busy_cyc += sel ? int'(busy_b) : int'(busy_a);
            hits     += sel ? int'(bounce_b) : int'(bounce_a);
            @(negedge clk);
        end
    endtask

    initial begin
        int bc, h, tot;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_x", x_a, 280);
        check("rst_y", y_a, 200);
        check("rst_dirs", {dx_a, dy_a}, 0);
        check("rst_busy", busy_a, 0);
        check("rst_bounce", bounce_a, 0);
        check("rst_cnt", cnt_a, 0);

        // Corner: both axes hit on the same frame -> a single pulse.
        run_frame(1, 4'd2, bc, h);
        check("corner_x", x_b, 5);
        check("corner_y", y_b, 5);
        check("corner_dirs", {dx_b, dy_b}, 3);
        check("corner_pulses", h, 1);
        check("corner_cnt", cnt_b, CE);

        run_frame(0, 4'd3, bc, h);
        check("first_x", x_a, 277);
        check("first_y", y_a, 197);
        check("first_dirs", {dx_a, dy_a}, 0);
        check("first_busy_cycles", bc, 3);
        check("first_pulses", h, 0);

        enable = 1'b0;
        run_frame(0, 4'd3, bc, h);
        enable = 1'b1;
        check("disabled_x", x_a, 277);
        check("disabled_busy", bc, 0);

        tot = 0;
        for (int f = 0; f < 18; f++) begin
            run_frame(0, 4'd15, bc, h);
            tot += h;
        end
        check("run_left_x", x_a, 7);
        check("run_left_y", y_a, 80);
        check("run_left_dirs", {dx_a, dy_a}, 1);
        check("run_left_pulses", tot, 1);
        check("run_left_cnt", cnt_a, CE);

        run_frame(0, 4'd3, bc, h);
        check("left_wall_x", x_a, 5);
        check("left_wall_dx", dx_a, 1);
        check("left_wall_y", y_a, 83);
        check("left_wall_pulses", h, 1);

        tot = 0;
        for (int f = 0; f < 36; f++) begin
            run_frame(0, 4'd15, bc, h);
            tot += h;
        end
        check("run_right_x", x_a, 545);
        check("run_right_y", y_a, 170);
        check("run_right_dirs", {dx_a, dy_a}, 2);
        check("run_right_pulses", tot, 1);

        run_frame(0, 4'd8, bc, h);
        check("near_wall_x", x_a, 553);
        run_frame(0, 4'd3, bc, h);
        check("right_wall_x", x_a, 555);
        check("right_wall_dx", dx_a, 0);
        check("right_wall_y", y_a, 159);
        check("right_wall_pulses", h, 1);
        check("right_wall_cnt", cnt_a, 4 * CE);

        // Refresh held for two edges: the second one lands in STEP_X.
        @(negedge clk);
        speed = 4'd3;
        refresh_a = 1'b1;
        repeat (2) @(negedge clk);
        refresh_a = 1'b0;
        repeat (6) @(negedge clk);
        check("double_refresh_x", x_a, 552);
        check("double_refresh_y", y_a, 156);

        run_frame(0, 4'd0, bc, h);
        check("zero_speed_x", x_a, 552);
        check("zero_speed_y", y_a, 156);
        check("zero_speed_busy", bc, 3);
        check("zero_speed_pulses", h, 0);

        // Reset during STEP_Y on both instances; dut_b would hit the corner.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        speed = 4'd3;
        refresh_a = 1'b1;
        refresh_b = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
        refresh_b = 1'b0;
        @(negedge clk);
        check("abort_in_step_y", busy_a & busy_b, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_x", x_a, 280);
        check("abort_y", y_a, 200);
        check("abort_busy", busy_a | busy_b, 0);
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            tot += int'(bounce_a) + int'(bounce_b);
            @(negedge clk);
        end
        check("abort_pulses", tot, 0);
        check("abort_corner_x", x_b, 5);
        check("abort_corner_dx", dx_b, 0);
        check("abort_cnt", cnt_b, 0);

        // Saturation: keep bouncing until well past 255 hits.
        tot = 0;
        for (int f = 0; f < 6000 && tot < 260; f++) begin
            run_frame(1, 4'd15, bc, h);
            tot += h;
        end
        check("sat_enough_hits", int'(tot >= 260), 1);
        check("sat_cnt", cnt_b, 255 * CE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
